uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DIVIDER, default 104, meaning clocks per serial bit period; SHALL be >= 4.
REQ-002 Parameter DEPTH, default 4, meaning receive FIFO depth in bytes; SHALL be a power of two.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 rx  input  1  asynchronous serial line, idle high, 8N1 format, LSB first.
REQ-006 rd_en  input  1  bus read strobe, one cycle per access.
REQ-007 addr  input  2  register select: 0 = data, 1 = status, 2..3 = reserved.
REQ-008 rd_data  output  8  registered read data.
REQ-009 rd_valid  output  1  registered pulse marking rd_data valid.
REQ-010 rx_ready  output  1  high while the FIFO is non-empty, derived from registered state.

Function
REQ-011 rx SHALL pass through a two-flop synchronizer; the receive FSM SHALL use only the second-stage output (rx_s).
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-013 IDLE: when rx_s is 0 -> START; bit counter loaded with DIVIDER/2 - 1.
REQ-014 The bit counter SHALL decrement every cycle outside IDLE and BREAK; a "sample point" is a cycle where it equals 0, after which it reloads DIVIDER - 1.
REQ-015 START sample point: rx_s = 1 -> IDLE (glitch rejected, nothing recorded); rx_s = 0 -> DATA, bit index 0.
REQ-016 DATA sample point: rx_s shifted into bit[index], LSB first; after bit 7 -> STOP.
REQ-017 STOP sample point, rx_s = 1: byte pushed into FIFO if not full, else byte dropped and overrun flag set; -> IDLE.
REQ-018 STOP sample point, rx_s = 0: byte discarded, frame flag set; -> BREAK.
REQ-019 BREAK: remain until rx_s = 1, then -> IDLE.
REQ-020 Read addr 0, FIFO non-empty: rd_data = oldest byte, byte popped.
REQ-021 Read addr 0, FIFO empty: rd_data = 0x00, no pop, no flag change.
REQ-022 Read addr 1: rd_data = {5'b0, frame, overrun, non-empty}; frame and overrun cleared by the same read.
REQ-023 Read addr 2 or 3: rd_data = 0x00, no side effects.
REQ-024 Every rd_en SHALL produce rd_valid = 1 for exactly the following cycle, with rd_data valid in that cycle; rd_valid = 0 otherwise.
REQ-025 rd_data SHALL hold its last value while rd_valid = 0.
REQ-026 Push and pop in the same cycle: both SHALL occur; when full, the push SHALL be accepted because of the pop, with no overrun.
REQ-027 Flag set and status-read clear in the same cycle: set SHALL win, and the flag remains 1.
REQ-028 FIFO pointers SHALL be log2(DEPTH) bits, wrap modulo DEPTH, with a separate count of log2(DEPTH)+1 bits; full = count == DEPTH.
REQ-029 Pushed-byte latency: rx_ready SHALL rise the cycle after the stop-bit sample point.

Reset
REQ-030 With rst_n = 0 at a clock edge: FSM = IDLE, counter and bit index = 0, synchronizer flops = 1, FIFO empty, flags = 0, rd_data = 0x00, rd_valid = 0, rx_ready = 0.
REQ-031 Reset mid-frame SHALL discard the partial byte; after release, reception SHALL start only on a new falling edge of rx_s.
REQ-032 rd_en during reset SHALL be ignored.

Verification (DIVIDER = 104, DEPTH = 4)
REQ-033 Drive 0x55 at 104 clk/bit, then read addr 0 -> rd_valid for one cycle after rd_en, rd_data = 0x55, rx_ready falls.
REQ-034 rx low pulse of 40 clocks, then high -> no push, rx_ready stays 0, status read = 0x00.
REQ-035 Send 0x01,0x02,0x03,0x04,0x05 with no reads -> status = 0x03; data reads return 0x01..0x04; fifth read returns 0x00; next status read = 0x00.
REQ-036 Send 0xA5 with stop bit held low for 3 bit times, then 0x3C -> status = 0x04 and no 0xA5 in the FIFO; 0x3C received correctly after rx returns high.
REQ-037 Assert rst_n = 0 for one cycle mid-data-bit of 0xFF -> all outputs at reset values, and the FIFO stays empty after the remaining bits.
REQ-038 Complete a stop bit with the FIFO full in the same cycle as an addr 0 read -> oldest byte returned, new byte stored, overrun = 0.

Source files
------------

// File: rtl/uart_rx_if.sv
// Register-read bus between a host and the UART receiver.
// rd_en is a one-cycle request with no back-pressure; rd_valid answers it exactly one cycle later and rd_data holds between answers.
interface uart_rx_if;
    logic       rd_en;
    logic [1:0] addr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rx_ready;

    modport master (output rd_en, output addr, input rd_data, input rd_valid, input rx_ready);
    modport slave  (input rd_en, input addr, output rd_data, output rd_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a small byte FIFO, sticky frame/overrun flags and a register read port.
// DEPTH must be a power of two of at least 2; DIVIDER must be at least 4.
module uart_rx #(
    parameter int DIVIDER = 104,
    parameter int DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    uart_rx_if.slave   bus,
    output logic [2:0] dbg_state
);
    localparam int CW = $clog2(DIVIDER);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state;
    logic          rx_m, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          frame, overrun;

    logic sample, full, pop, push_req, push, overrun_set, frame_set, status_rd;

    always_comb begin
        sample      = (cnt == '0);
        full        = (count == (AW+1)'(DEPTH));
        pop         = bus.rd_en && (bus.addr == 2'd0) && (count != '0);
        push_req    = (state == STOP) && sample && rx_s;
        // A pop in the same cycle frees the slot the new byte needs.
        push        = push_req && (!full || pop);
        overrun_set = push_req && full && !pop;
        frame_set   = (state == STOP) && sample && !rx_s;
        status_rd   = bus.rd_en && (bus.addr == 2'd1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= CW'(DIVIDER / 2 - 1);
                    end
                end
                START: begin
                    if (sample) begin
                        cnt     <= CW'(DIVIDER - 1);
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (sample) begin
                        cnt            <= CW'(DIVIDER - 1);
                        shift[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (sample) begin
                        cnt   <= CW'(DIVIDER - 1);
                        state <= rx_s ? IDLE : BREAK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            frame        <= 1'b0;
            overrun      <= 1'b0;
            bus.rd_data  <= 8'h00;
            bus.rd_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Setting outranks a simultaneous status-read clear.
            if (frame_set)      frame <= 1'b1;
            else if (status_rd) frame <= 1'b0;
            if (overrun_set)    overrun <= 1'b1;
            else if (status_rd) overrun <= 1'b0;

            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                case (bus.addr)
                    2'd0:    bus.rd_data <= pop ? mem[rd_ptr] : 8'h00;
                    2'd1:    bus.rd_data <= {5'b0, frame, overrun, (count != '0)};
                    default: bus.rd_data <= 8'h00;
                endcase
            end
        end
    end

    assign bus.rx_ready = (count != '0);
    assign dbg_state    = state;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed table of frames, multi-cycle corner sequences, then random traffic against a queue model.
module tb_uart_rx;
    localparam int DIVIDER = 104;
    localparam int DEPTH   = 4;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [2:0] dbg_state;

    uart_rx_if bus();

    uart_rx #(.DIVIDER(DIVIDER), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // scoreboard state
    logic [7:0] exp_q[$];
    logic       m_frame;
    logic       m_overrun;

    typedef struct {
        logic [7:0] data;
        int         stop_low_bits;
        logic [7:0] exp_status;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // All driver tasks start and end just after a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        m_frame   = 1'b0;
        m_overrun = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] data, input int stop_low_bits);
        rx = 1'b0;
        repeat (DIVIDER) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (DIVIDER) @(negedge clk);
        end
        if (stop_low_bits > 0) begin
            rx = 1'b0;
            repeat (DIVIDER * stop_low_bits) @(negedge clk);
        end
        rx = 1'b1;
        repeat (DIVIDER) @(negedge clk);
    endtask

    task automatic check_read(input logic [1:0] a, input logic [7:0] exp, input string name);
        bus.rd_en = 1'b1;
        bus.addr  = a;
        @(negedge clk);
        bus.rd_en = 1'b0;
        bus.addr  = 2'd0;
        check({name, "_valid"}, {7'b0, bus.rd_valid}, 8'h01);
        check(name, bus.rd_data, exp);
        @(negedge clk);
        check({name, "_valid_drop"}, {7'b0, bus.rd_valid}, 8'h00);
        check({name, "_hold"}, bus.rd_data, exp);
    endtask

    // reference model operations
    task automatic model_frame(input logic [7:0] data, input logic bad);
        if (bad) m_frame = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(data);
        else m_overrun = 1'b1;
    endtask

    function automatic logic [7:0] model_status();
        return {5'b0, m_frame, m_overrun, (exp_q.size() != 0)};
    endfunction

    initial begin
        logic [7:0] d;
        logic [7:0] e;
        int         op;

        rst_n     = 1'b0;
        rx        = 1'b1;
        bus.rd_en = 1'b0;
        bus.addr  = 2'd0;
        m_frame   = 1'b0;
        m_overrun = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rd_data", bus.rd_data, 8'h00);
        check("reset_rd_valid", {7'b0, bus.rd_valid}, 8'h00);
        check("reset_rx_ready", {7'b0, bus.rx_ready}, 8'h00);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // directed frames: data, stop-low bit times, status after frame, first data read
        vecs[0] = '{8'h55, 0, 8'h01, 8'h55};
        vecs[1] = '{8'h00, 0, 8'h01, 8'h00};
        vecs[2] = '{8'hFF, 0, 8'h01, 8'hFF};
        vecs[3] = '{8'hA5, 3, 8'h04, 8'h00};
        vecs[4] = '{8'h3C, 0, 8'h01, 8'h3C};
        for (int i = 0; i < 5; i++) begin
            send_byte(vecs[i].data, vecs[i].stop_low_bits);
            check($sformatf("vec%0d_rx_ready", i), {7'b0, bus.rx_ready}, {7'b0, vecs[i].exp_status[0]});
            check_read(2'd1, vecs[i].exp_status, $sformatf("vec%0d_status", i));
            check_read(2'd0, vecs[i].exp_data, $sformatf("vec%0d_data", i));
            check($sformatf("vec%0d_ready_fall", i), {7'b0, bus.rx_ready}, 8'h00);
        end
        check_read(2'd2, 8'h00, "reserved2");
        check_read(2'd3, 8'h00, "reserved3");

        // short low glitch must be rejected
        do_reset();
        rx = 1'b0;
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (2 * DIVIDER) @(negedge clk);
        check("glitch_rx_ready", {7'b0, bus.rx_ready}, 8'h00);
        check_read(2'd1, 8'h00, "glitch_status");

        // overrun: five bytes into a four-deep FIFO
        do_reset();
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 0);
        check_read(2'd1, 8'h03, "ovr_status");
        for (int i = 1; i <= 4; i++) check_read(2'd0, 8'(i), $sformatf("ovr_data%0d", i));
        check_read(2'd0, 8'h00, "ovr_empty_read");
        check_read(2'd1, 8'h00, "ovr_status_clear");

        // stop-bit sample point (edge 991 after the start bit) coincides with a data read on a full FIFO
        do_reset();
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 0);
        fork
            send_byte(8'h06, 0);
            begin
                repeat (990) @(negedge clk);
                bus.rd_en = 1'b1;
                bus.addr  = 2'd0;
                @(negedge clk);
                bus.rd_en = 1'b0;
                check("full_pop_valid", {7'b0, bus.rd_valid}, 8'h01);
                check("full_pop_data", bus.rd_data, 8'h01);
            end
        join
        check_read(2'd1, 8'h01, "full_pop_status");
        check_read(2'd0, 8'h02, "full_pop_d2");
        check_read(2'd0, 8'h03, "full_pop_d3");
        check_read(2'd0, 8'h04, "full_pop_d4");
        check_read(2'd0, 8'h06, "full_pop_d6");

        // reset in the middle of a data bit, with a read strobe during reset
        do_reset();
        send_byte(8'h5A, 0);
        check_read(2'd1, 8'h01, "mid_pre_status");
        fork
            send_byte(8'hFF, 0);
            begin
                repeat (300) @(negedge clk);
                rst_n     = 1'b0;
                bus.rd_en = 1'b1;
                bus.addr  = 2'd0;
                @(negedge clk);
                rst_n     = 1'b1;
                bus.rd_en = 1'b0;
                check("mid_rst_rd_data", bus.rd_data, 8'h00);
                check("mid_rst_rd_valid", {7'b0, bus.rd_valid}, 8'h00);
                check("mid_rst_rx_ready", {7'b0, bus.rx_ready}, 8'h00);
                @(negedge clk);
                check("mid_rst_rd_valid_after", {7'b0, bus.rd_valid}, 8'h00);
            end
        join
        check("mid_rst_fifo_empty", {7'b0, bus.rx_ready}, 8'h00);
        check_read(2'd1, 8'h00, "mid_rst_status");

        // random traffic against the queue model
        do_reset();
        for (int n = 0; n < 24; n++) begin
            op = $urandom_range(0, 5);
            case (op)
                0, 1, 2: begin
                    d = 8'($urandom_range(0, 255));
                    send_byte(d, 0);
                    model_frame(d, 1'b0);
                end
                3: begin
                    d = 8'($urandom_range(0, 255));
                    send_byte(d, 2);
                    model_frame(d, 1'b1);
                end
                4: begin
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                    check_read(2'd0, e, $sformatf("rnd%0d_data", n));
                end
                default: begin
                    e = model_status();
                    m_frame   = 1'b0;
                    m_overrun = 1'b0;
                    check_read(2'd1, e, $sformatf("rnd%0d_status", n));
                end
            endcase
            check($sformatf("rnd%0d_rx_ready", n), {7'b0, bus.rx_ready}, {7'b0, (exp_q.size() != 0)});
        end
        e = model_status();
        m_frame   = 1'b0;
        m_overrun = 1'b0;
        check_read(2'd1, e, "rnd_final_status");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_read(2'd0, e, "rnd_drain");
        end
        check_read(2'd0, 8'h00, "rnd_drain_empty");

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
